// File: rtl/rv32i_instr_encoder.sv
// RV32I mnemonic-to-machine-word encoder that streams encoded instructions
// into instruction memory at an auto-incrementing word address.
module rv32i_instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

    state_t state, state_nxt;

    logic [4:0]  op_p0, rd_p0, rs1_p0, rs2_p0;
    logic [31:0] imm_p0;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;

    // True when v[31:msb] are all the same bit (value fits a signed field).
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << msb;
        return ((v & m) == m) || ((v & m) == 32'd0);
    endfunction

    function automatic logic [2:0] r_funct3(input logic [4:0] op);
        case (op)
            5'd2:    return 3'b001;
            5'd3:    return 3'b010;
            5'd4:    return 3'b011;
            5'd5:    return 3'b100;
            5'd6,
            5'd7:    return 3'b101;
            5'd8:    return 3'b110;
            5'd9:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] i_funct3(input logic [4:0] op);
        case (op)
            5'd11:   return 3'b001;
            5'd12:   return 3'b010;
            5'd13:   return 3'b011;
            5'd14:   return 3'b100;
            5'd15,
            5'd16:   return 3'b101;
            5'd17:   return 3'b110;
            5'd18:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] b_funct3(input logic [4:0] op);
        case (op)
            5'd22:   return 3'b001;
            5'd23:   return 3'b100;
            5'd24:   return 3'b101;
            5'd25:   return 3'b110;
            5'd26:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && !full;
    assign accept   = in_valid && in_ready && !clear;
    assign imem_we  = (state == WR) && !clear;
    assign full     = count[ADDR_W];

    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        if (op_p0 <= 5'd9) begin
            enc_word = {((op_p0 == 5'd1) || (op_p0 == 5'd7)) ? 7'b0100000 : 7'b0000000,
                        rs2_p0, rs1_p0, r_funct3(op_p0), rd_p0, 7'b0110011};
        end else if (op_p0 <= 5'd18) begin
            // SLLI / SRLI / SRAI carry a 5-bit shamt with funct7 above it.
            if ((op_p0 == 5'd11) || (op_p0 == 5'd15) || (op_p0 == 5'd16)) begin
                enc_legal = (imm_p0[31:5] == 27'd0);
                enc_word  = {(op_p0 == 5'd16) ? 7'b0100000 : 7'b0000000, imm_p0[4:0],
                             rs1_p0, i_funct3(op_p0), rd_p0, 7'b0010011};
            end else begin
                enc_legal = fits_signed(imm_p0, 11);
                enc_word  = {imm_p0[11:0], rs1_p0, i_funct3(op_p0), rd_p0, 7'b0010011};
            end
        end else begin
            case (op_p0)
                5'd19: begin
                    enc_legal = fits_signed(imm_p0, 11);
                    enc_word  = {imm_p0[11:0], rs1_p0, 3'b010, rd_p0, 7'b0000011};
                end
                5'd20: begin
                    enc_legal = fits_signed(imm_p0, 11);
                    enc_word  = {imm_p0[11:5], rs2_p0, rs1_p0, 3'b010, imm_p0[4:0], 7'b0100011};
                end
                5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26: begin
                    enc_legal = !imm_p0[0] && fits_signed(imm_p0, 12);
                    enc_word  = {imm_p0[12], imm_p0[10:5], rs2_p0, rs1_p0, b_funct3(op_p0),
                                 imm_p0[4:1], imm_p0[11], 7'b1100011};
                end
                5'd27: begin
                    enc_legal = !imm_p0[0] && fits_signed(imm_p0, 20);
                    enc_word  = {imm_p0[20], imm_p0[10:1], imm_p0[11], imm_p0[19:12],
                                 rd_p0, 7'b1101111};
                end
                5'd28: begin
                    enc_legal = fits_signed(imm_p0, 11);
                    enc_word  = {imm_p0[11:0], rs1_p0, 3'b000, rd_p0, 7'b1100111};
                end
                5'd29:   enc_word = {imm_p0[31:12], rd_p0, 7'b0110111};
                5'd30:   enc_word = {imm_p0[31:12], rd_p0, 7'b0010111};
                default: enc_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = ENC;
                ENC:     state_nxt = enc_legal ? WR : IDLE;
                WR:      state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0: capture the instruction fields at the handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= in_op;
            rd_p0  <= in_rd;
            rs1_p0 <= in_rs1;
            rs2_p0 <= in_rs2;
            imm_p0 <= in_imm;
        end
    end

    // Stage p1: register the encoded word and address for the write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            err        <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                if ((state == ENC) && !enc_legal)
                    err <= 1'b1;
                if ((state == ENC) && enc_legal) begin
                    imem_addr  <= count[ADDR_W-1:0];
                    imem_wdata <= enc_word;
                end
                if (state == WR)
                    count <= count + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomized bench for rv32i_instr_encoder against an arithmetic reference
// encoder with a small capacity (ADDR_W = 2) so full/clear paths occur often.
module tb_rv32i_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [4:0]    in_op, in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full, err;

    int n_checks = 0;
    int n_errors = 0;
    int m_count  = 0;
    bit m_err    = 0;
    logic [31:0] m_mem [CAP];

    int r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int i_f3 [9]  = '{0, 1, 2, 3, 4, 5, 5, 6, 7};
    int b_f3 [6]  = '{0, 1, 4, 5, 6, 7};

    rv32i_instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoder: fields placed by arithmetic from the ISA layouts.
    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input int imm, output bit legal);
        logic [31:0] u, w, f3, f7, fld;
        u = imm;
        w = 0;
        legal = 1;
        if (op <= 9) begin
            f3 = r_f3[op];
            f7 = (op == 1 || op == 7) ? 32 : 0;
            w = 51 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
        end else if (op <= 18) begin
            f3 = i_f3[op-10];
            if (op == 11 || op == 15 || op == 16) begin
                legal = (imm >= 0) && (imm <= 31);
                fld = (u & 31) + ((op == 16) ? 1024 : 0);
            end else begin
                legal = (imm >= -2048) && (imm <= 2047);
                fld = u & 4095;
            end
            w = 19 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld << 20);
        end else if (op == 19 || op == 28) begin
            legal = (imm >= -2048) && (imm <= 2047);
            w = ((op == 19) ? 3 + (2 << 12) : 103) + (rd << 7) + (rs1 << 15) + ((u & 4095) << 20);
        end else if (op == 20) begin
            legal = (imm >= -2048) && (imm <= 2047);
            w = 35 + ((u & 31) << 7) + (2 << 12) + (rs1 << 15) + (rs2 << 20)
                + (((u >> 5) & 127) << 25);
        end else if (op <= 26) begin
            f3 = b_f3[op-21];
            legal = ((imm % 2) == 0) && (imm >= -4096) && (imm <= 4095);
            w = 99 + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + (f3 << 12)
                + (rs1 << 15) + (rs2 << 20) + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
        end else if (op == 27) begin
            legal = ((imm % 2) == 0) && (imm >= -(1 << 20)) && (imm < (1 << 20));
            w = 111 + (rd << 7) + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20)
                + (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
        end else if (op == 29 || op == 30) begin
            w = ((op == 29) ? 55 : 23) + (rd << 7) + (u & 32'hFFFF_F000);
        end else begin
            legal = 0;
        end
        return w;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".full"}, 32'(full), 32'(m_count == CAP));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".ready"}, 32'(in_ready), 32'(m_count != CAP));
    endtask

    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm);
        bit legal;
        logic [31:0] w;
        int ptr;
        w = ref_encode(op, rd, rs1, rs2, imm, legal);
        ptr = m_count % CAP;
        @(negedge clk);
        in_valid = 1; in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2); in_imm = imm;
        #1 chk("hs.ready", 32'(in_ready), 32'(m_count != CAP));
        @(negedge clk);
        in_valid = 0; in_op = 5'($urandom); in_imm = $urandom;
        #1 chk("enc.we", 32'(imem_we), 0);
        if (m_count == CAP) begin
            @(negedge clk);
            #1 chk("full.we", 32'(imem_we), 0);
            check_status("full");
            return;
        end
        chk("enc.ready", 32'(in_ready), 0);
        @(negedge clk);
        #1;
        if (legal) begin
            chk("wr.we", 32'(imem_we), 1);
            chk("wr.addr", 32'(imem_addr), 32'(ptr));
            chk("wr.wdata", imem_wdata, w);
            chk("wr.ready", 32'(in_ready), 0);
            m_mem[ptr] = w;
            m_count++;
        end else begin
            chk("ill.we", 32'(imem_we), 0);
            chk("ill.err", 32'(err), 1);
            m_err = 1;
        end
        @(negedge clk);
        #1 chk("post.we", 32'(imem_we), 0);
        check_status("post");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        m_count = 0;
        m_err = 0;
        #1 check_status("clear");
    endtask

    initial begin
        rst_n = 0; clear = 0; in_valid = 0;
        in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.addr", 32'(imem_addr), 0);
        chk("rst.wdata", imem_wdata, 0);
        chk("rst.we", 32'(imem_we), 0);
        check_status("rst");
        @(negedge clk);
        rst_n = 1;

        issue(0, 3, 1, 2, 0);
        chk("add.word", m_mem[0], 32'h002081B3);
        do_clear();
        issue(1, 5, 6, 7, 0);
        issue(10, 1, 0, 0, -1);
        issue(16, 2, 2, 0, 3);
        chk("sub.word", m_mem[0], 32'h407302B3);
        chk("addi.word", m_mem[1], 32'hFFF00093);
        chk("srai.word", m_mem[2], 32'h40315113);
        do_clear();
        issue(20, 0, 1, 2, 8);
        issue(21, 0, 1, 2, -4);
        issue(27, 1, 0, 0, 8);
        issue(29, 5, 0, 0, 32'h12345000);
        chk("sw.word", m_mem[0], 32'h0020A423);
        chk("beq.word", m_mem[1], 32'hFE208EE3);
        chk("jal.word", m_mem[2], 32'h008000EF);
        chk("lui.word", m_mem[3], 32'h123452B7);
        issue(0, 1, 1, 1, 0);
        do_clear();
        issue(10, 1, 1, 0, 2048);
        issue(21, 0, 1, 2, 3);
        issue(31, 1, 2, 3, 0);
        issue(9, 4, 5, 6, 0);
        do_clear();

        // Async reset while the instruction sits in ENC.
        @(negedge clk);
        in_valid = 1; in_op = 0; in_rd = 1; in_rs1 = 2; in_rs2 = 3; in_imm = 0;
        @(negedge clk);
        in_valid = 0;
        rst_n = 0;
        #1 chk("arst.ready", 32'(in_ready), 1);
        @(negedge clk);
        #1 chk("arst.we", 32'(imem_we), 0);
        rst_n = 1;
        m_count = 0; m_err = 0;
        @(negedge clk);
        #1 check_status("arst");

        // Clear arriving in the WR cycle suppresses the write.
        @(negedge clk);
        in_valid = 1; in_op = 0; in_rd = 1; in_rs1 = 2; in_rs2 = 3; in_imm = 0;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        clear = 1;
        #1 chk("clrwr.we", 32'(imem_we), 0);
        @(negedge clk);
        clear = 0;
        #1 check_status("clrwr");

        for (int i = 0; i < 200; i++) begin
            int imm;
            if ($urandom_range(0, 11) == 0) do_clear();
            case ($urandom_range(0, 5))
                0:       imm = int'($urandom);
                1:       imm = int'($urandom_range(0, 4095)) - 2048;
                2:       imm = int'($urandom_range(0, 31));
                3:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                4:       imm = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
                default: imm = int'($urandom_range(0, 8191)) - 4096;
            endcase
            issue(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_instr_encoder.md
# rv32i_instr_encoder

Sequential RV32I instruction encoder and program loader, the inverse of the control decoder. It accepts one mnemonic-level instruction per valid/ready handshake: an operation code, register indices and an immediate. It packs these into the 32-bit RV32I machine word, range-checks the immediate, and writes the word into instruction memory at an auto-incrementing word address. It is used by the FPGA bring-up path to load test programs without an external assembler.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; resets the write pointer, word count, `full` and `err`.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  encoder can accept an instruction.
- in_op  in  5  mnemonic code (see Operation).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte-offset or immediate value.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written since reset or `clear`.
- full  out  1  count == 2^ADDR_W.
- err  out  1  sticky; set when an illegal op or an out-of-range immediate is detected.

## Operation
- **Mnemonic codes (in_op):**
  - 0–9 = ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - 10–18 = ADDI SLLI SLTI SLTIU XORI SRLI SRAI ORI ANDI.
  - 19 = LW, 20 = SW.
  - 21–26 = BEQ BNE BLT BGE BLTU BGEU.
  - 27 = JAL, 28 = JALR, 29 = LUI, 30 = AUIPC.
  - 31 = illegal.
- **Opcodes and funct fields:**
  - R-type: 0110011. SUB and SRA use funct7 0100000; all others 0000000.
  - I-type ALU: 0010011. SRAI uses imm[11:5] = 0100000.
  - LW: 0000011, funct3 010. SW: 0100011, funct3 010.
  - Branches: 1100011, funct3 000/001/100/101/110/111.
  - JAL: 1101111. JALR: 1100111, funct3 000. LUI: 0110111. AUIPC: 0010111.
- **Bit packing:** standard RV32I R/I/S/B/U/J layouts. Unused fields are zero (e.g. rs2 in I-type, rd in S/B).
- **Immediate legality:**
  - I/S (incl. LW, SW, JALR): in_imm[31:11] all equal.
  - Shift-immediate: in_imm[31:5] == 0.
  - B: in_imm[0] == 0 and in_imm[31:12] all equal.
  - J: in_imm[0] == 0 and in_imm[31:20] all equal.
  - U: uses in_imm[31:12]; in_imm[11:0] ignored and always legal.
- **State machine:**
  - IDLE: in_ready = !full. On in_valid && in_ready, latch all fields and go to ENC.
  - ENC: compute the word and legality, register the result. If legal go to WR; if illegal set err and go to IDLE.
  - WR: imem_we = 1, imem_addr = pointer, imem_wdata = encoded word. Then increment pointer and count, and go to IDLE.
- **Illegal instruction:** produces no write; pointer and count are unchanged.
- **Pointer:** wraps naturally at 2^ADDR_W, but `full` blocks further acceptance first.
- **clear:**
  - Forces IDLE, pointer = 0, count = 0, err = 0.
  - An in-flight instruction (ENC or WR) is aborted and not written.
  - clear wins over a simultaneous in_valid; nothing is accepted that cycle.

## Timing
- **Reset values:** state IDLE, in_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, count = 0, full = 0, err = 0.
- **Latency:**
  - Handshake at edge N.
  - ENC during cycle N+1.
  - imem_we high during cycle N+2 only.
  - in_ready high again from cycle N+3.
- **Throughput:** one instruction per 3 cycles.
- in_ready is low in ENC and WR. Fields need not be held after the handshake.
- count and full update at the edge ending WR.
- imem_addr/imem_wdata hold their last values outside WR.
- Async reset asserted mid-instruction: outputs go to reset values immediately; no write completes.

## Test plan
- ADD x3,x1,x2 (op 0, rd 3, rs1 1, rs2 2) -> one we pulse at handshake+2, addr 0, wdata 0x002081B3, count 1.
- Back-to-back SUB x5,x6,x7; ADDI x1,x0,-1; SRAI x2,x2,3 -> addrs 0,1,2 with wdata 0x407302B3, 0xFFF00093, 0x40315113; in_ready low 2 cycles after each handshake.
- SW x2,8(x1); BEQ x1,x2,-4; JAL x1,8; LUI x5,0x12345000 -> 0x0020A423, 0xFE208EE3, 0x008000EF, 0x123452B7.
- ADDI imm 2048, BEQ imm 3, op 31 -> no we pulse, err = 1 and stays set, count unchanged; clear -> err = 0.
- ADDR_W = 2: 4 legal writes -> full = 1, in_ready = 0, a 5th in_valid is ignored; clear -> full = 0, next write at addr 0.
- rst_n low during ENC -> no we pulse; clear asserted during WR -> no write, count 0.
